uart_rx_buffer: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_rx_buffer.sv | 109 ++++++++++
 tb/tb_uart_rx_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side logic.
package uart_pkg;

  localparam int UART_WORD_W = 16;

  typedef logic [UART_WORD_W-1:0] uart_word_t;

  typedef enum logic {
    IDLE,
    CLR
  } rxbuf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with first-word-fall-through read.
// The caller qualifies push and pop; a push is only issued when the FIFO is not full or a pop occurs in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;

  // NOTE: storage has no reset; only pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (level_q == '0);
  assign level   = level_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffers words from the UART receiver into a FIFO and releases the receiver via ready_clr.
// Define UART_RX_BUF_STATS_EN to add the rx_count / drop_count statistics outputs.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk_50m,
  input  logic                   rst_n,
  input  logic                   rx_ready,
  input  logic [UART_WORD_W-1:0] rx_data,
  output logic                   rx_ready_clr,
  output logic [UART_WORD_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [AW:0]            level,
  output logic                   overflow,
  input  logic                   ovf_clr
`ifdef UART_RX_BUF_STATS_EN
  ,
  output logic [15:0]            rx_count,
  output logic [7:0]             drop_count
`endif
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  rxbuf_state_e state_q, state_d;
  logic         push_req, push, pop, drop, fifo_empty;
  logic         rx_ready_clr_q;
  logic         overflow_q, overflow_d;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    case (state_q)
      IDLE: if (rx_ready) begin
        push_req = 1'b1;
        state_d  = CLR;
      end
      CLR:     if (!rx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO still takes the word when the head leaves in the same cycle.
  assign pop        = m_valid && m_ready;
  assign push       = push_req && ((level != FULL_LVL) || pop);
  assign drop       = push_req && !push;
  assign overflow_d = drop || (overflow_q && !ovf_clr);

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rx_ready_clr_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      rx_ready_clr_q <= (state_d == CLR);
      overflow_q     <= overflow_d;
    end
  end

  assign rx_ready_clr = rx_ready_clr_q;
  assign overflow     = overflow_q;
  assign m_valid      = !fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_WORD_W)
  ) u_fifo (
    .clk     (clk_50m),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (rx_data),
    .pop     (pop),
    .rd_data (m_data),
    .empty   (fifo_empty),
    .level   (level)
  );

`ifdef UART_RX_BUF_STATS_EN
  logic [15:0] rx_count_q, rx_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  always_comb begin
    rx_count_d   = rx_count_q + 16'(push);
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      rx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rx_count   = rx_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Directed bench for uart_rx_buffer: table of push/pop steps plus multi-cycle corner sequences.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int DEPTH = 16;

  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        rx_ready;
  logic [15:0] rx_data;
  logic        rx_ready_clr;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  level;
  logic        overflow;
  logic        ovf_clr;
`ifdef UART_RX_BUF_STATS_EN
  logic [15:0] rx_count;
  logic [7:0]  drop_count;
`endif

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
`ifdef UART_RX_BUF_STATS_EN
    ,
    .rx_count     (rx_count),
    .drop_count   (drop_count)
`endif
  );

  always #10 clk_50m = ~clk_50m;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  // Holds rx_ready until ready_clr rises, then drops it and waits for ready_clr to fall.
  task automatic send_word(input logic [15:0] d);
    int t;
    rx_data  = d;
    rx_ready = 1'b1;
    t = 0;
    do begin step(); t++; end while (!rx_ready_clr && t < 20);
    if (!rx_ready_clr) check("clr_rise_timeout", {31'd0, rx_ready_clr}, 32'd1);
    rx_ready = 1'b0;
    t = 0;
    do begin step(); t++; end while (rx_ready_clr && t < 20);
    if (rx_ready_clr) check("clr_fall_timeout", {31'd0, rx_ready_clr}, 32'd0);
  endtask

  // Pop monitor: records each word the consumer accepts at the following edge.
  logic       mon_en = 1'b0;
  logic [15:0] popped[$];
  always @(negedge clk_50m) begin
    if (mon_en && m_valid && m_ready) popped.push_back(m_data);
  end

  typedef struct {
    logic        is_pop;
    logic [15:0] data;
    logic [4:0]  exp_level;
    logic        exp_valid;
    logic [15:0] exp_head;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 16'h1234, 5'd2, 1'b1, 16'hA55A};
    vecs[1] = '{1'b0, 16'hBEEF, 5'd3, 1'b1, 16'hA55A};
    vecs[2] = '{1'b1, 16'h0000, 5'd2, 1'b1, 16'h1234};
    vecs[3] = '{1'b1, 16'h0000, 5'd1, 1'b1, 16'hBEEF};
    vecs[4] = '{1'b0, 16'h0000, 5'd2, 1'b1, 16'hBEEF};
    vecs[5] = '{1'b1, 16'h0000, 5'd1, 1'b1, 16'h0000};
    vecs[6] = '{1'b1, 16'h0000, 5'd0, 1'b0, 16'h0000};
    vecs[7] = '{1'b1, 16'h0000, 5'd0, 1'b0, 16'h0000};
    vecs[8] = '{1'b0, 16'hFFFF, 5'd1, 1'b1, 16'hFFFF};
    vecs[9] = '{1'b1, 16'h0000, 5'd0, 1'b0, 16'h0000};

    rst_n    = 1'b0;
    rx_ready = 1'b0;
    rx_data  = '0;
    m_ready  = 1'b0;
    ovf_clr  = 1'b0;
    step();
    step();
    check("rst_clr",      {31'd0, rx_ready_clr}, 32'd0);
    check("rst_valid",    {31'd0, m_valid},      32'd0);
    check("rst_level",    {27'd0, level},        32'd0);
    check("rst_overflow", {31'd0, overflow},     32'd0);
    rst_n = 1'b1;
    step();

    // Single word: push at the edge that first sees rx_ready
    rx_data  = 16'hA55A;
    rx_ready = 1'b1;
    step();
    check("single_valid", {31'd0, m_valid},      32'd1);
    check("single_level", {27'd0, level},        32'd1);
    check("single_data",  {16'd0, m_data},       32'h0000A55A);
    check("single_clr_hi", {31'd0, rx_ready_clr}, 32'd1);
    rx_ready = 1'b0;
    step();
    check("single_clr_lo", {31'd0, rx_ready_clr}, 32'd0);
    check("single_level2", {27'd0, level},        32'd1);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_pop) begin
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
      end else begin
        send_word(vecs[i].data);
      end
      check($sformatf("vec%0d_level", i), {27'd0, level},   {27'd0, vecs[i].exp_level});
      check($sformatf("vec%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_head", i), {16'd0, m_data}, {16'd0, vecs[i].exp_head});
    end

    // Order and wrap: 40 words streamed through with the consumer always ready
    popped.delete();
    mon_en  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 40; i++) send_word(16'(i));
    step();
    step();
    mon_en  = 1'b0;
    m_ready = 1'b0;
    check("order_count", popped.size(), 32'd40);
    for (int i = 0; i < 40; i++) begin
      if (i < popped.size()) check($sformatf("order_word%0d", i), {16'd0, popped[i]}, 32'(i));
    end
    check("order_ovf",   {31'd0, overflow}, 32'd0);
    check("order_level", {27'd0, level},    32'd0);

    // Overflow: 17 words into an unserviced FIFO
    for (int i = 0; i < 16; i++) send_word(16'(i));
    send_word(16'h00EE);
    check("ovf_level", {27'd0, level},    32'd16);
    check("ovf_flag",  {31'd0, overflow}, 32'd1);
    check("ovf_head",  {16'd0, m_data},   32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    // A drop in the same cycle as ovf_clr leaves the flag set
    rx_data  = 16'h00DD;
    rx_ready = 1'b1;
    ovf_clr  = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_set_wins", {31'd0, overflow}, 32'd1);
    check("ovf_level2",   {27'd0, level},    32'd16);
    rx_ready = 1'b0;
    step();
    check("ovf_clr_lo", {31'd0, rx_ready_clr}, 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("ovf_drain%0d", i), {16'd0, m_data}, 32'(i));
      step();
    end
    m_ready = 1'b0;
    check("ovf_drained_valid", {31'd0, m_valid}, 32'd0);
    check("ovf_drained_level", {27'd0, level},   32'd0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_final_clr", {31'd0, overflow}, 32'd0);

    // Full FIFO with a pop in the capture cycle
    for (int i = 0; i < 16; i++) send_word(16'h0200 + 16'(i));
    check("fullpop_pre_level", {27'd0, level}, 32'd16);
    rx_data  = 16'h02AA;
    rx_ready = 1'b1;
    m_ready  = 1'b1;
    step();
    m_ready = 1'b0;
    check("fullpop_level", {27'd0, level},        32'd16);
    check("fullpop_ovf",   {31'd0, overflow},     32'd0);
    check("fullpop_clr",   {31'd0, rx_ready_clr}, 32'd1);
    check("fullpop_head",  {16'd0, m_data},       32'h00000201);
    rx_ready = 1'b0;
    step();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fullpop_drain%0d", i), {16'd0, m_data},
            (i < 15) ? 32'h0201 + 32'(i) : 32'h02AA);
      step();
    end
    m_ready = 1'b0;
    check("fullpop_empty", {31'd0, m_valid}, 32'd0);

    // Reset while in CLR with rx_ready still high
    rx_data  = 16'hC0DE;
    rx_ready = 1'b1;
    step();
    check("rstclr_pre_clr",   {31'd0, rx_ready_clr}, 32'd1);
    check("rstclr_pre_level", {27'd0, level},        32'd1);
    rst_n = 1'b0;
    step();
    check("rstclr_clr",   {31'd0, rx_ready_clr}, 32'd0);
    check("rstclr_level", {27'd0, level},        32'd0);
    check("rstclr_valid", {31'd0, m_valid},      32'd0);
    rst_n = 1'b1;
    step();
    check("rstclr_recap_level", {27'd0, level},        32'd1);
    check("rstclr_recap_data",  {16'd0, m_data},       32'h0000C0DE);
    check("rstclr_recap_clr",   {31'd0, rx_ready_clr}, 32'd1);
    rx_ready = 1'b0;
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("rstclr_final_level", {27'd0, level}, 32'd0);

`ifdef UART_RX_BUF_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("stats_rst_rx",   {16'd0, rx_count},   32'd0);
    check("stats_rst_drop", {24'd0, drop_count}, 32'd0);
    for (int i = 0; i < 20; i++) send_word(16'h0300 + 16'(i));
    check("stats_rx",    {16'd0, rx_count},   32'd16);
    check("stats_drop",  {24'd0, drop_count}, 32'd4);
    check("stats_level", {27'd0, level},      32'd16);
    check("stats_ovf",   {31'd0, overflow},   32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
